clock_meter: RTL

- Measures an external, asynchronous periodic signal, e.g. a divided clock leaving another board or an off-chip strobe.
- Synchronizes the input and emits one-cycle rise/fall strobes.
- Reports the period and high time in clk cycles, plus valid and stalled status.
- Sits at the receive end of clock-generator outputs, for board bring-up and frequency monitoring.

---
 rtl/clock_meter_pkg.sv | 19 +
 rtl/clock_meter_edge_sync.sv | 47 ++++
 rtl/clock_meter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/clock_meter_pkg.sv
// clock_meter shared definitions
// state encoding and synchronizer constants
package clock_meter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_STALL = 2'd3;

  localparam int SYNC_STAGES  = 2;
  localparam int PRIME_CYCLES = 3;

  function automatic logic is_active(state_t s);
    return (s == ST_ARMED) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/clock_meter_edge_sync.sv
// edge_sync: metastability chain, delay flop and
// start-up mask producing rise/fall detect pulses
module edge_sync
  import clock_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise_det,
  output logic fall_det
);

  localparam int PW = $clog2(PRIME_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic [PW-1:0]          r_prime;
  logic                   w_s2;
  logic                   w_primed;

  assign w_s2     = r_sync[SYNC_STAGES-1];
  assign w_primed = (r_prime == PW'(PRIME_CYCLES));

  // two-flop synchronizer plus one delay stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in};
      r_dly  <= w_s2;
    end
  end

  // hide edges until the chain holds real samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prime <= '0;
    end else if (!w_primed) begin
      r_prime <= r_prime + PW'(1);
    end
  end

  assign rise_det = w_primed &  w_s2 & ~r_dly;
  assign fall_det = w_primed & ~w_s2 &  r_dly;

endmodule

// File: rtl/clock_meter.sv
// clock_meter: period / high-time meter for an
// asynchronous periodic input with stall detect
module clock_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic             rise,
  output logic             fall,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] LP_TMO =
    WIDTH'(TIMEOUT - 1);

  logic             w_rise_det;
  logic             w_fall_det;
  logic             w_tmo;
  logic             w_active;
  logic [WIDTH-1:0] w_cnt_inc;
  state_t           w_state_nxt;
  logic             w_valid;
  logic             w_stalled;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high;
  logic             r_rise;
  logic             r_fall;

  edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .in       (sig_in),
    .rise_det (w_rise_det),
    .fall_det (w_fall_det)
  );

  assign w_cnt_inc = (&r_cnt) ? r_cnt
                              : r_cnt + WIDTH'(1);
  assign w_active  = is_active(r_state);
  assign w_tmo     = (r_cnt == LP_TMO) & ~w_rise_det;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next state; a rise beats a same-cycle timeout
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise_det) w_state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (w_rise_det) w_state_nxt = ST_RUN;
          else if (w_tmo) w_state_nxt = ST_STALL;
        end
        ST_RUN: begin
          if (w_tmo) w_state_nxt = ST_STALL;
        end
        ST_STALL: begin
          if (w_rise_det) w_state_nxt = ST_ARMED;
        end
      endcase
    end
  end

  // status decode from the registered state
  always_comb begin
    w_valid   = (r_state == ST_RUN);
    w_stalled = (r_state == ST_STALL);
  end

  // cycle counter, restarted at each rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_cnt <= '0;
    else if (!en)        r_cnt <= '0;
    else if (w_rise_det) r_cnt <= '0;
    else                 r_cnt <= w_cnt_inc;
  end

  // one-cycle edge strobes, silenced while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= en & w_rise_det;
      r_fall <= en & w_fall_det;
    end
  end

  // measurements only from a run that saw a rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period <= '0;
      r_high   <= '0;
    end else if (en && w_active) begin
      if (w_rise_det) r_period <= w_cnt_inc;
      if (w_fall_det) r_high   <= w_cnt_inc;
    end
  end

  assign rise      = r_rise;
  assign fall      = r_fall;
  assign period    = r_period;
  assign high_time = r_high;
  assign valid     = w_valid;
  assign stalled   = w_stalled;

endmodule
